load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: max cycles waited in REQ or RESP before abort; legal range 2..255.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port mem_en  in  1  current instruction is a load or store; held stable by the pipeline while stall=1.
REQ-005 SHALL have port MemRW  in  1  1=store, 0=load.
REQ-006 SHALL have port MemSize  in  2  00=byte, 01=half, 10=word, 11=illegal.
REQ-007 SHALL have port MemUnsigned  in  1  1=zero-extend load, 0=sign-extend.
REQ-008 SHALL have port addr  in  32  byte address (ALU result).
REQ-009 SHALL have port wdata  in  32  store data (rs2).
REQ-010 SHALL have port stall  out  1  holds the pipeline.
REQ-011 SHALL have port rdata  out  32  extended load result.
REQ-012 SHALL have port rdata_valid  out  1  one-cycle load-complete pulse.
REQ-013 SHALL have port misalign  out  1  one-cycle misaligned/illegal-size pulse.
REQ-014 SHALL have port bus_err  out  1  one-cycle timeout pulse.
REQ-015 SHALL have ports bus_req out 1, bus_we out 1, bus_addr out 32, bus_be out 4, bus_wdata out 32  memory request.
REQ-016 SHALL have ports bus_gnt in 1, bus_rvalid in 1, bus_rdata in 32  memory response.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, RESP, DONE.
REQ-018 IDLE: on mem_en=1, SHALL latch MemRW, MemSize, MemUnsigned, addr, wdata, then go to REQ if legal, else to DONE with the error flag set.
REQ-019 Legal access: MemSize≠11; half needs addr[0]=0; word needs addr[1:0]=00.
REQ-020 stall SHALL be combinational: 1 when (IDLE and mem_en) or REQ or RESP; 0 in DONE.
REQ-021 REQ: bus_req=1; bus_addr={addr[31:2],2'b00}; bus_we=MemRW; bus_req, bus_we, bus_addr, bus_be and bus_wdata SHALL stay stable until bus_gnt=1.
REQ-022 On bus_gnt=1 in REQ: store SHALL go to DONE; load SHALL go to RESP; bus_req SHALL be 0 from the next cycle.
REQ-023 RESP: on bus_rvalid=1, SHALL register the extended bus_rdata into rdata and go to DONE.
REQ-024 bus_rvalid SHALL be ignored outside RESP.
REQ-025 DONE: SHALL last exactly one cycle, then go to IDLE; mem_en during DONE SHALL be ignored (it is the completing instruction).
REQ-026 rdata_valid, misalign and bus_err SHALL be registered and high only in the DONE cycle of the relevant access.
REQ-027 Minimum latency: store with bus_gnt in the first REQ cycle: stall high 2 cycles; load with bus_rvalid one cycle after bus_gnt: stall high 3 cycles.
REQ-028 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-029 bus_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-030 Load extraction: select the byte/half at lane addr[1:0], then sign- or zero-extend per MemUnsigned; word passes through.
REQ-031 A cycle counter SHALL clear on entry to REQ or RESP and increment in each cycle spent there.
REQ-032 When the counter reaches TIMEOUT without bus_gnt/bus_rvalid: bus_req SHALL drop, the FSM SHALL go to DONE with bus_err=1, and rdata SHALL be unchanged.
REQ-033 Misaligned/illegal and timeout accesses SHALL never assert rdata_valid.
REQ-034 A store SHALL never assert rdata_valid.

Reset
REQ-035 While rst_n=0: state=IDLE, counter=0, and bus_req, bus_we, bus_addr, bus_be, bus_wdata, rdata, rdata_valid, misalign, bus_err all 0, taking effect immediately.
REQ-036 Reset asserted mid-REQ or mid-RESP SHALL abandon the access; a later bus_rvalid SHALL be ignored.

Verification
REQ-037 SW addr=0x104 wdata=0xDEADBEEF, bus_gnt after 2 cycles -> bus_addr=0x104, be=1111, bus_wdata=0xDEADBEEF, bus_we=1; stall falls in the DONE cycle; no rdata_valid.
REQ-038 LB addr=0x203 bus_rdata=0x80000000 -> rdata=0xFFFFFF80, rdata_valid pulse; LBU same -> 0x00000080.
REQ-039 SH addr=0x102 wdata=0x00001234 -> be=1100, bus_wdata=0x12341234.
REQ-040 LH addr=0x102 bus_rdata=0x80017F00 -> rdata=0xFFFF8001.
REQ-041 LW addr=0x101 -> no bus_req, misalign pulse in DONE, stall high exactly 1 cycle; MemSize=11 behaves the same.
REQ-042 LW with bus_gnt held 0 -> bus_err pulse after TIMEOUT=16 REQ cycles, bus_req low afterward.
REQ-043 LW with rst_n pulsed low in RESP -> outputs 0 immediately; a bus_rvalid arriving later produces no rdata_valid.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns one pipeline memory instruction into a single
// request/response transaction on a simple memory bus, stalling the
// pipeline until the access completes, is rejected, or times out.
//
// Bus handshake: bus_req is the request valid and bus_gnt is its ready.
// A request transfers in the cycle where bus_req=1 and bus_gnt=1. Until then
// bus_req, bus_we, bus_addr, bus_be and bus_wdata are held stable. A load
// then waits for bus_rvalid, which carries bus_rdata. bus_rvalid is only
// honoured while a load response is outstanding.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_en,
  input  logic        MemRW,
  input  logic [1:0]  MemSize,
  input  logic        MemUnsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [7:0]  cnt_inc;
  logic        timeout;
  logic        lat_rw;
  logic        lat_uns;
  logic [1:0]  lat_size;
  logic [1:0]  lat_lane;
  logic        legal;
  logic        set_rvalid;
  logic        set_misalign;
  logic        set_err;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] shifted;
  logic [31:0] ext;

  assign cnt_inc = cnt + 8'd1;
  // The current wait cycle is the TIMEOUT-th one spent in REQ or RESP.
  assign timeout = (cnt_inc == 8'(TIMEOUT));

  // The pipeline is held from the moment a memory instruction shows up until
  // the DONE cycle, where it is released.
  assign stall = ((state == IDLE) && mem_en) || (state == REQ) || (state == RESP);

  // Alignment/size legality and bus lane formatting of the incoming instruction.
  always_comb begin
    legal     = 1'b1;
    be_nxt    = 4'b1111;
    wdata_nxt = wdata;
    case (MemSize)
      2'b00: begin
        be_nxt    = 4'b0001 << addr[1:0];
        wdata_nxt = {4{wdata[7:0]}};
      end
      2'b01: begin
        legal     = ~addr[0];
        be_nxt    = 4'b0011 << addr[1:0];
        wdata_nxt = {2{wdata[15:0]}};
      end
      2'b10:   legal = (addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // Pick the addressed lane out of the response word and extend it.
  always_comb begin
    shifted = bus_rdata >> {lat_lane, 3'b000};
    ext     = bus_rdata;
    case (lat_size)
      2'b00:   ext = lat_uns ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   ext = lat_uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ext = bus_rdata;
    endcase
  end

  // Next-state logic and the completion flags reported in DONE.
  always_comb begin
    state_nxt    = state;
    set_rvalid   = 1'b0;
    set_misalign = 1'b0;
    set_err      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_en) begin
          if (legal) begin
            state_nxt = REQ;
          end else begin
            state_nxt    = DONE;
            set_misalign = 1'b1;
          end
        end
      end
      REQ: begin
        if (bus_gnt) begin
          state_nxt = lat_rw ? DONE : RESP;
        end else if (timeout) begin
          state_nxt = DONE;
          set_err   = 1'b1;
        end
      end
      RESP: begin
        if (bus_rvalid) begin
          state_nxt  = DONE;
          set_rvalid = 1'b1;
        end else if (timeout) begin
          state_nxt = DONE;
          set_err   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Request latching, bus outputs, wait counter, load result and pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= 8'd0;
      lat_rw      <= 1'b0;
      lat_uns     <= 1'b0;
      lat_size    <= 2'b00;
      lat_lane    <= 2'b00;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= 32'h0;
      bus_be      <= 4'h0;
      bus_wdata   <= 32'h0;
      rdata       <= 32'h0;
      rdata_valid <= 1'b0;
      misalign    <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      rdata_valid <= set_rvalid;
      misalign    <= set_misalign;
      bus_err     <= set_err;

      if ((state_nxt != state) && ((state_nxt == REQ) || (state_nxt == RESP)))
        cnt <= 8'd0;
      else if ((state == REQ) || (state == RESP))
        cnt <= cnt_inc;

      if ((state == IDLE) && mem_en) begin
        lat_rw    <= MemRW;
        lat_uns   <= MemUnsigned;
        lat_size  <= MemSize;
        lat_lane  <= addr[1:0];
        bus_req   <= legal;
        bus_we    <= MemRW;
        bus_addr  <= {addr[31:2], 2'b00};
        bus_be    <= be_nxt;
        bus_wdata <= wdata_nxt;
      end

      if ((state == REQ) && (state_nxt != REQ))
        bus_req <= 1'b0;

      if (set_rvalid)
        rdata <= ext;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, sign/zero-extended loads,
// misaligned and illegal accesses, request timeout and reset mid-access.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        mem_en;
  logic        MemRW;
  logic [1:0]  MemSize;
  logic        MemUnsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        misalign;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int total = 0;
  int bad   = 0;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .mem_en(mem_en), .MemRW(MemRW),
    .MemSize(MemSize), .MemUnsigned(MemUnsigned), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .misalign(misalign), .bus_err(bus_err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge (input drive point).
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic issue(input logic rw, input logic [1:0] size, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_en      = 1'b1;
    MemRW       = rw;
    MemSize     = size;
    MemUnsigned = uns;
    addr        = a;
    wdata       = wd;
  endtask

  // Load with grant in the first REQ cycle and rvalid one cycle later.
  task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                         input logic [31:0] a, input logic [31:0] rd,
                         input logic [31:0] exp_word, input logic [31:0] exp_rdata);
    cyc(); issue(1'b0, size, uns, a, 32'h0); #1;
    chk({tag, "_stall_idle"}, stall, 1);
    cyc(); bus_gnt = 1'b1; #1;
    chk({tag, "_req"}, bus_req, 1);
    chk({tag, "_we"}, bus_we, 0);
    chk({tag, "_addr"}, bus_addr, exp_word);
    cyc(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = rd; #1;
    chk({tag, "_req_dropped"}, bus_req, 0);
    chk({tag, "_stall_resp"}, stall, 1);
    cyc(); bus_rvalid = 1'b0; #1;
    chk({tag, "_rvalid"}, rdata_valid, 1);
    chk({tag, "_rdata"}, rdata, exp_rdata);
    chk({tag, "_stall_done"}, stall, 0);
    cyc(); mem_en = 1'b0; #1;
    chk({tag, "_rvalid_pulse"}, rdata_valid, 0);
  endtask

  // Illegal access: straight to DONE with a misalign pulse, no bus activity.
  task automatic do_bad(input string tag, input logic [1:0] size, input logic [31:0] a,
                        input logic [31:0] keep_rdata);
    cyc(); issue(1'b0, size, 1'b0, a, 32'h0); bus_rvalid = 1'b1; bus_rdata = 32'h12345678; #1;
    chk({tag, "_stall_idle"}, stall, 1);
    cyc(); #1;
    chk({tag, "_misalign"}, misalign, 1);
    chk({tag, "_no_req"}, bus_req, 0);
    chk({tag, "_stall_done"}, stall, 0);
    chk({tag, "_no_rvalid"}, rdata_valid, 0);
    chk({tag, "_rdata_kept"}, rdata, keep_rdata);
    cyc(); mem_en = 1'b0; bus_rvalid = 1'b0; #1;
    chk({tag, "_misalign_pulse"}, misalign, 0);
    chk({tag, "_no_rvalid_after"}, rdata_valid, 0);
  endtask

  // Directed sequence.
  initial begin
    rst_n = 1'b0; mem_en = 1'b0; MemRW = 1'b0; MemSize = 2'b00; MemUnsigned = 1'b0;
    addr = 32'h0; wdata = 32'h0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;

    // Reset state.
    cyc(); cyc(); #1;
    chk("rst_stall", stall, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_be", bus_be, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_flags", {rdata_valid, misalign, bus_err}, 0);
    cyc(); rst_n = 1'b1;

    // SW 0x104, grant in the second REQ cycle.
    cyc(); issue(1'b1, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF); #1;
    chk("sw_stall_idle", stall, 1);
    chk("sw_req_idle", bus_req, 0);
    cyc(); #1;
    chk("sw_req1", bus_req, 1);
    chk("sw_addr1", bus_addr, 32'h104);
    chk("sw_be1", bus_be, 4'b1111);
    chk("sw_wdata1", bus_wdata, 32'hDEADBEEF);
    chk("sw_we1", bus_we, 1);
    cyc(); bus_gnt = 1'b1; #1;
    chk("sw_req2", bus_req, 1);
    chk("sw_addr2", bus_addr, 32'h104);
    chk("sw_wdata2", bus_wdata, 32'hDEADBEEF);
    chk("sw_stall2", stall, 1);
    cyc(); bus_gnt = 1'b0; #1;
    chk("sw_stall_done", stall, 0);
    chk("sw_req_done", bus_req, 0);
    chk("sw_no_rvalid", rdata_valid, 0);
    chk("sw_no_err", {misalign, bus_err}, 0);
    cyc(); mem_en = 1'b0; #1;
    chk("sw_idle_stall", stall, 0);
    chk("sw_idle_req", bus_req, 0);

    // SH 0x102, grant in the first REQ cycle: stall high two cycles.
    cyc(); issue(1'b1, 2'b01, 1'b0, 32'h102, 32'h00001234); #1;
    chk("sh_stall_idle", stall, 1);
    cyc(); bus_gnt = 1'b1; #1;
    chk("sh_be", bus_be, 4'b1100);
    chk("sh_wdata", bus_wdata, 32'h12341234);
    chk("sh_addr", bus_addr, 32'h100);
    chk("sh_stall_req", stall, 1);
    cyc(); bus_gnt = 1'b0; #1;
    chk("sh_stall_done", stall, 0);
    chk("sh_no_rvalid", rdata_valid, 0);
    cyc(); mem_en = 1'b0; #1;
    chk("sh_idle_req", bus_req, 0);

    // Loads with extension.
    do_load("lb",  2'b00, 1'b0, 32'h203, 32'h80000000, 32'h200, 32'hFFFFFF80);
    do_load("lbu", 2'b00, 1'b1, 32'h203, 32'h80000000, 32'h200, 32'h00000080);
    do_load("lh",  2'b01, 1'b0, 32'h102, 32'h80017F00, 32'h100, 32'hFFFF8001);
    do_load("lw",  2'b10, 1'b0, 32'h300, 32'hCAFEF00D, 32'h300, 32'hCAFEF00D);

    // Misaligned word and illegal size; rdata keeps the last load value.
    do_bad("lw_mis",  2'b10, 32'h101, 32'hCAFEF00D);
    do_bad("lh_mis",  2'b01, 32'h103, 32'hCAFEF00D);
    do_bad("sz_ill",  2'b11, 32'h100, 32'hCAFEF00D);

    // LW with no grant: 16 REQ cycles, then bus_err in DONE.
    cyc(); issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0); #1;
    chk("to_stall_idle", stall, 1);
    for (int i = 0; i < 16; i++) begin
      cyc(); #1;
      chk("to_req_held", {bus_req, bus_err, stall}, 3'b101);
    end
    cyc(); #1;
    chk("to_bus_err", bus_err, 1);
    chk("to_req_low", bus_req, 0);
    chk("to_stall_done", stall, 0);
    chk("to_no_rvalid", rdata_valid, 0);
    chk("to_rdata_kept", rdata, 32'hCAFEF00D);
    cyc(); mem_en = 1'b0; #1;
    chk("to_err_pulse", bus_err, 0);
    chk("to_req_after", bus_req, 0);

    // LW with reset asserted in RESP; late rvalid must be ignored.
    cyc(); issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    cyc(); bus_gnt = 1'b1;
    cyc(); bus_gnt = 1'b0; #1;
    chk("rr_in_resp", stall, 1);
    #1 rst_n = 1'b0; mem_en = 1'b0; #1;
    chk("rr_stall", stall, 0);
    chk("rr_bus_addr", bus_addr, 0);
    chk("rr_bus_we_req", {bus_we, bus_req}, 0);
    chk("rr_rdata", rdata, 0);
    cyc(); rst_n = 1'b1;
    cyc(); bus_rvalid = 1'b1; bus_rdata = 32'h55AA55AA;
    cyc(); bus_rvalid = 1'b0; #1;
    chk("rr_no_rvalid", rdata_valid, 0);
    chk("rr_rdata_zero", rdata, 0);
    chk("rr_stall_idle", stall, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
